// File: rtl/uart_tx.sv
// 8-bit UART transmitter, 8N1 by default, LSB first, txd idles high.
// Define UART_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD=1).
module uart_tx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int PARITY_ODD = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_enable,
    output logic       tx_ready,
    output logic       txd
);

    // CLK_FREQ/BAUD must come out at 2 or more for the bit timing to work.
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;

`ifdef UART_PARITY_EN
    // Parity is taken from the byte as accepted, since shift is consumed.
    logic par;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            par <= 1'b0;
        else if (state == IDLE && tx_enable)
            par <= (^tx_data) ^ (PARITY_ODD != 0);
    end
`else
    // PARITY_ODD has no meaning in an 8N1 build; sink it explicitly.
    logic unused_parity_odd;
    assign unused_parity_odd = (PARITY_ODD != 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            txd      <= 1'b1;
            tx_ready <= 1'b1;
            cnt      <= '0;
            idx      <= '0;
            shift    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (tx_enable) begin
                        shift    <= tx_data;
                        state    <= START;
                        txd      <= 1'b0;
                        tx_ready <= 1'b0;
                    end
                end

                START: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        idx   <= '0;
                        txd   <= shift[0];
                        state <= DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        shift <= {1'b0, shift[7:1]};
                        idx   <= idx + 3'd1;
                        if (idx == 3'd7) begin
`ifdef UART_PARITY_EN
                            txd   <= par;
                            state <= PARITY;
`else
                            txd   <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            txd <= shift[1];
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

`ifdef UART_PARITY_EN
                PARITY: begin
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        txd   <= 1'b1;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif

                STOP: begin
                    if (cnt == LAST) begin
                        cnt      <= '0;
                        state    <= IDLE;
                        tx_ready <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state    <= IDLE;
                    txd      <= 1'b1;
                    tx_ready <= 1'b1;
                    cnt      <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected bytes, a serial
// receiver process decodes txd and checks against the queue.
module tb_uart_tx;

    localparam int CPB     = 10;
    localparam int PAR_ODD = 0;
`ifdef UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_enable = 1'b0;
    logic       tx_ready;
    logic       txd;

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQ(1000), .BAUD(100), .PARITY_ODD(PAR_ODD)) dut (
        .clk      (clk),
        .rst      (rst),
        .tx_data  (tx_data),
        .tx_enable(tx_enable),
        .tx_ready (tx_ready),
        .txd      (txd)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc   = 0;
    bit         b2b   = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mwait(input int n, inout bit ab);
        repeat (n) begin
            @(negedge clk);
            if (rst) ab = 1'b1;
        end
    endtask

    // Serial receiver: samples each bit in the middle of its period.
    initial begin : monitor
        logic [7:0] b, e;
        logic       s0, sp, pb;
        bit         ab;
        int         st, prev;
        prev = -1;
        pb   = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                ab = 1'b0;
                st = cyc;
                mwait(4, ab);
                s0 = txd;
                for (int i = 0; i < 8; i++) begin
                    mwait(10, ab);
                    b[i] = txd;
                end
`ifdef UART_PARITY_EN
                mwait(10, ab);
                pb = txd;
`endif
                mwait(10, ab);
                sp = txd;
                if (!ab) begin
                    chk("start_bit", {31'd0, s0}, 32'd0);
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL unexpected_frame: got %0h expected none", b);
                    end else begin
                        e = exp_q.pop_front();
                        chk("frame_data", {24'd0, b}, {24'd0, e});
`ifdef UART_PARITY_EN
                        chk("parity_bit", {31'd0, pb}, {31'd0, (^e) ^ (PAR_ODD != 0)});
`endif
                    end
                    chk("stop_bit", {31'd0, sp}, 32'd1);
                    if (b2b) begin
                        if (prev >= 0) chk("b2b_spacing", st - prev, FRAME + 1);
                        prev = st;
                    end else begin
                        prev = -1;
                    end
                end
            end
        end
    end

    // tx_ready must be low for exactly one frame per accepted byte.
    initial begin : ready_check
        int run;
        bit ra;
        run = 0;
        ra  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) ra = 1'b1;
            if (tx_ready === 1'b0) begin
                run++;
            end else begin
                if (run > 0 && !ra) chk("ready_low_clks", run, FRAME);
                run = 0;
                ra  = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit expect_it);
        if (expect_it) exp_q.push_back(d);
        tx_data   = d;
        tx_enable = 1'b1;
        @(posedge clk);
        #1 tx_enable = 1'b0;
        chk("start_txd", {31'd0, txd}, 32'd0);
        chk("busy_ready", {31'd0, tx_ready}, 32'd0);
    endtask

    task automatic wait_ready(input int bound);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < bound; k++) begin
            if (tx_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_ready: got timeout expected ready within %0d clks", bound);
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit r, acc;
        // Reset asserted between edges must take effect without a clock.
        #2 rst = 1'b1;
        #1;
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_ready", {31'd0, tx_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_txd", {31'd0, txd}, 32'd1);

        send(8'h2B, 1'b1);
        wait_ready(FRAME + 20);
        repeat (5) @(posedge clk);
        #1;

        // Request at clk 35 of a frame is dropped; tx_data change is harmless.
        send(8'hA5, 1'b1);
        repeat (34) @(posedge clk);
        #1 tx_data = 8'hFF;
        tx_enable = 1'b1;
        @(posedge clk);
        #1 tx_enable = 1'b0;
        chk("busy_pulse_ready", {31'd0, tx_ready}, 32'd0);
        wait_ready(FRAME + 20);
        repeat (150) @(posedge clk);
        #1;
        chk("busy_queue_empty", exp_q.size(), 0);

        b2b = 1'b1;
        tx_enable = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tx_data = 8'(i);
            exp_q.push_back(8'(i));
            acc = 1'b0;
            for (int k = 0; k < 300 && !acc; k++) begin
                @(negedge clk);
                r = tx_ready;
                @(posedge clk);
                #1;
                acc = r;
            end
            if (!acc) begin
                n_cmp++;
                n_err++;
                $display("FAIL b2b_accept: got timeout expected accept of byte %0d", i);
            end
        end
        tx_enable = 1'b0;
        wait_ready(FRAME + 20);
        repeat (20) @(posedge clk);
        #1 b2b = 1'b0;

        // 8'h96 bit 3 is 0, so the reset visibly drives txd back high.
        send(8'h96, 1'b0);
        repeat (43) @(posedge clk);
        #4 rst = 1'b1;
        #1;
        chk("midrst_txd", {31'd0, txd}, 32'd1);
        chk("midrst_ready", {31'd0, tx_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        send(8'h3C, 1'b1);
        wait_ready(FRAME + 20);
        repeat (20) @(posedge clk);
        #1;

        chk("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
